buzzer_pattern_gen: RTL and testbench

Parametrised buzzer driver that succeeds the fixed-rate buzzer test wrapper. It generates a square-wave tone at a programmable half-period and gates it into a beep pattern: N beeps of programmable on/off length, or a continuous tone. It sits between the lab control logic and the buzzer pin. It replaces the free-running divider with a start/stop, busy/done handshake.

---
 rtl/buzzer_pattern_gen.sv | 147 ++++++++++++++
 tb/tb_buzzer_pattern_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_pattern_gen.sv
// Beep-pattern buzzer driver: square-wave tone gated into N beeps or a continuous tone.
// Define BUZZER_SWEEP_EN to add a per-beep saturating half-period sweep (sweep_step input).
module buzzer_pattern_gen #(
  parameter int DIV_WIDTH = 20,
  parameter int DUR_WIDTH = 24,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] half_period,
  input  logic [DUR_WIDTH-1:0] on_cycles,
  input  logic [DUR_WIDTH-1:0] off_cycles,
  input  logic [CNT_WIDTH-1:0] beep_count,
`ifdef BUZZER_SWEEP_EN
  input  logic [7:0]           sweep_step,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 outClk
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TONE = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]           state;
  logic [DIV_WIDTH-1:0] hp_q;
  logic [DUR_WIDTH-1:0] on_q;
  logic [DUR_WIDTH-1:0] off_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] tone_cnt;
  logic [DUR_WIDTH-1:0] dur_cnt;
  logic [CNT_WIDTH-1:0] beeps_done;
  logic [CNT_WIDTH-1:0] beeps_nxt;
  logic                 tone_end;
  logic                 gap_end;
  logic                 last_beep;

`ifdef BUZZER_SWEEP_EN
  logic [7:0]           step_q;

  function automatic logic [DIV_WIDTH-1:0] sat_add(input logic [DIV_WIDTH-1:0] a,
                                                    input logic [7:0] b);
    logic [DIV_WIDTH:0] s;
    s = {1'b0, a} + (DIV_WIDTH+1)'(b);
    return s[DIV_WIDTH] ? {DIV_WIDTH{1'b1}} : s[DIV_WIDTH-1:0];
  endfunction
`endif

  assign busy      = (state != S_IDLE);
  assign beeps_nxt = beeps_done + CNT_WIDTH'(1);
  assign tone_end  = (dur_cnt == on_q - DUR_WIDTH'(1));
  assign gap_end   = (dur_cnt == off_q - DUR_WIDTH'(1));
  // beep_count of 0 is continuous: beeps_done may wrap without ever finishing
  assign last_beep = (cnt_q != '0) && (beeps_nxt == cnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      outClk     <= 1'b0;
      hp_q       <= '0;
      on_q       <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      tone_cnt   <= '0;
      dur_cnt    <= '0;
      beeps_done <= '0;
`ifdef BUZZER_SWEEP_EN
      step_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= S_IDLE;
        outClk     <= 1'b0;
        tone_cnt   <= '0;
        dur_cnt    <= '0;
        beeps_done <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && (on_cycles != '0)) begin
              state      <= S_TONE;
              hp_q       <= (half_period == '0) ? DIV_WIDTH'(1) : half_period;
              on_q       <= on_cycles;
              off_q      <= off_cycles;
              cnt_q      <= beep_count;
`ifdef BUZZER_SWEEP_EN
              step_q     <= sweep_step;
`endif
              outClk     <= 1'b0;
              tone_cnt   <= '0;
              dur_cnt    <= '0;
              beeps_done <= '0;
            end
          end
          S_TONE: begin
            if (tone_end) begin
              // every beep (and gap) starts from a low, freshly phased tone
              beeps_done <= beeps_nxt;
              tone_cnt   <= '0;
              dur_cnt    <= '0;
              outClk     <= 1'b0;
`ifdef BUZZER_SWEEP_EN
              hp_q       <= sat_add(hp_q, step_q);
`endif
              if (last_beep) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else if (off_q == '0) begin
                state <= S_TONE;
              end else begin
                state <= S_GAP;
              end
            end else begin
              dur_cnt <= dur_cnt + DUR_WIDTH'(1);
              if (tone_cnt == hp_q - DIV_WIDTH'(1)) begin
                tone_cnt <= '0;
                outClk   <= ~outClk;
              end else begin
                tone_cnt <= tone_cnt + DIV_WIDTH'(1);
              end
            end
          end
          S_GAP: begin
            outClk <= 1'b0;
            if (gap_end) begin
              state    <= S_TONE;
              dur_cnt  <= '0;
              tone_cnt <= '0;
            end else begin
              dur_cnt <= dur_cnt + DUR_WIDTH'(1);
            end
          end
          default: begin
            state  <= S_IDLE;
            outClk <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// Self-checking bench for buzzer_pattern_gen: pattern-level model compared every cycle,
// plus directed literal checks. Sweep scenarios build when BUZZER_SWEEP_EN is defined.
module tb_buzzer_pattern_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [19:0] half_period;
  logic [23:0] on_cycles;
  logic [23:0] off_cycles;
  logic [3:0]  beep_count;
  logic [7:0]  sweep_step;
  logic        busy;
  logic        done;
  logic        outClk;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  buzzer_pattern_gen dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .half_period (half_period),
    .on_cycles   (on_cycles),
    .off_cycles  (off_cycles),
    .beep_count  (beep_count),
`ifdef BUZZER_SWEEP_EN
    .sweep_step  (sweep_step),
`endif
    .busy        (busy),
    .done        (done),
    .outClk      (outClk)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern model: elapsed time since start and the latched parameters.
  bit     m_act = 0;
  bit     m_done = 0;
  longint m_t, m_hp0, m_on, m_off, m_n, m_step;
  longint hp_max = (64'd1 << 20) - 1;

  function automatic longint hp_of(input longint b);
    longint h;
    h = m_hp0;
`ifdef BUZZER_SWEEP_EN
    h = m_hp0 + b * m_step;
    if (h > hp_max) h = hp_max;
`endif
    return h;
  endfunction

  function automatic logic exp_out();
    longint p, b, o;
    if (!m_act) return 1'b0;
    p = m_on + m_off;
    b = m_t / p;
    o = m_t % p;
    if (o >= m_on) return 1'b0;
    return 1'(((o / hp_of(b)) % 2));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act  = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_act) begin
        if (stop) m_act = 0;
        else begin
          m_t++;
          if (m_n != 0 && m_t == m_n * m_on + (m_n - 1) * m_off) begin
            m_act  = 0;
            m_done = 1;
          end
        end
      end else if (start && !stop && on_cycles != 0) begin
        m_act  = 1;
        m_t    = 0;
        m_hp0  = (half_period == 0) ? 1 : longint'(half_period);
        m_on   = longint'(on_cycles);
        m_off  = longint'(off_cycles);
        m_n    = longint'(beep_count);
        m_step = longint'(sweep_step);
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", 64'(busy), 64'(m_act));
    chk("cyc_done", 64'(done), 64'(m_done));
    chk("cyc_outclk", 64'(outClk), 64'(exp_out()));
  end

  logic ob [0:63];
  logic bb [0:63];
  logic db [0:63];

  task automatic capture(input int n, input int chg_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ob[i] = outClk;
      bb[i] = busy;
      db[i] = done;
      start = 1'b0;
      if (i == chg_at) begin
        half_period = 20'd7;
        start = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] seq(input int lo, input int len);
    logic [31:0] r = '0;
    for (int k = 0; k < len; k++) r = {r[30:0], ob[lo+k]};
    return r;
  endfunction

  function automatic int nbusy(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(bb[k]);
    return c;
  endfunction

  function automatic int ndone(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) c += int'(db[k]);
    return c;
  endfunction

  task automatic go(input int hp, input int on, input int off, input int n, input int st);
    @(negedge clk);
    half_period = 20'(hp);
    on_cycles   = 24'(on);
    off_cycles  = 24'(off);
    beep_count  = 4'(n);
    sweep_step  = 8'(st);
    start       = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 0; stop = 0;
    half_period = 0; on_cycles = 0; off_cycles = 0; beep_count = 0; sweep_step = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_outclk", 64'(outClk), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // two beeps with a gap
    go(2, 8, 4, 2, 0);
    capture(24, -1);
    chk("t1_beep1", 64'(seq(0, 8)), 64'h33);
    chk("t1_gap", 64'(seq(8, 4)), 64'h0);
    chk("t1_beep2", 64'(seq(12, 8)), 64'h33);
    chk("t1_busy_len", 64'(nbusy(24)), 64'd20);
    chk("t1_done_at20", 64'(db[20]), 64'd1);
    chk("t1_idle_at20", 64'(bb[20]), 64'd0);
    chk("t1_done_cnt", 64'(ndone(24)), 64'd1);

    // continuous tone then stop
    go(3, 6, 0, 0, 0);
    capture(40, -1);
    chk("t2_beep0", 64'(seq(0, 6)), 64'h07);
    chk("t2_rephase", 64'(seq(6, 6)), 64'h07);
    chk("t2_tail", 64'(seq(36, 4)), 64'h1);
    chk("t2_no_done", 64'(ndone(40)), 64'd0);
    chk("t2_busy_all", 64'(nbusy(40)), 64'd40);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t2_stop_busy", 64'(busy), 64'd0);
    chk("t2_stop_outclk", 64'(outClk), 64'd0);
    chk("t2_stop_done", 64'(done), 64'd0);

    // start with stop, start with on=0
    go(2, 8, 4, 2, 0);
    stop = 1'b1;
    capture(3, -1);
    stop = 1'b0;
    chk("t3_startstop_busy", 64'(nbusy(3)), 64'd0);
    chk("t3_startstop_done", 64'(ndone(3)), 64'd0);
    go(2, 0, 4, 2, 0);
    capture(3, -1);
    chk("t3_on0_busy", 64'(nbusy(3)), 64'd0);
    chk("t3_on0_done", 64'(ndone(3)), 64'd0);

    // input change and start while busy
    go(2, 8, 4, 2, 0);
    capture(24, 5);
    chk("t4_beep1", 64'(seq(0, 8)), 64'h33);
    chk("t4_beep2", 64'(seq(12, 8)), 64'h33);
    chk("t4_busy_len", 64'(nbusy(24)), 64'd20);
    chk("t4_done_cnt", 64'(ndone(24)), 64'd1);

    // async reset during gap
    go(2, 4, 6, 3, 0);
    capture(6, -1);
    chk("t5_in_gap", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_outclk", 64'(outClk), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    capture(20, -1);
    chk("t5_no_resume", 64'(nbusy(20)), 64'd0);
    chk("t5_no_done", 64'(ndone(20)), 64'd0);

`ifdef BUZZER_SWEEP_EN
    go(2, 12, 0, 3, 1);
    capture(40, -1);
    chk("sw_hp2", 64'(seq(0, 12)), 64'h333);
    chk("sw_hp3", 64'(seq(12, 12)), 64'h1C7);
    chk("sw_hp4", 64'(seq(24, 12)), 64'h0F0);
    chk("sw_done_at36", 64'(db[36]), 64'd1);
    go(20'hFFFFF, 8, 0, 2, 5);
    capture(20, -1);
    chk("sw_sat", 64'(seq(0, 16)), 64'h0);
    chk("sw_sat_done", 64'(db[16]), 64'd1);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
